proc_cycle_sequencer: RTL and testbench

Multi-cycle control FSM for the 32-bit five-field ISA processor core. It fetches each instruction through an imem request/acknowledge handshake and decodes it. It then sequences the ALU, data memory and register-file write port one stage per clock, and handles arithmetic-overflow exceptions by writing the status register ($30, rstatus). It replaces the ad-hoc divided imem/dmem/regfile/processor clocks with one clock plus enables.

---
 rtl/proc_ctrl_pkg.sv | 49 ++++
 rtl/insn_field_decode.sv | 63 ++++++
 rtl/proc_cycle_sequencer.sv | 207 ++++++++++++++++++++
 tb/tb_proc_cycle_sequencer.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_ctrl_pkg.sv
// Shared constants and types for the multi-cycle processor control path.
// Holds opcode/ALU-op encodings, the sequencer state enum, the
// exception codes written into rstatus, and the regfile write-data
// mux encodings.
package proc_ctrl_pkg;

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_ADDI  = 5'b00101;
  localparam logic [4:0] OP_SW    = 5'b00111;
  localparam logic [4:0] OP_LW    = 5'b01000;

  localparam logic [4:0] ALU_ADD  = 5'b00000;
  localparam logic [4:0] ALU_SUB  = 5'b00001;
  localparam logic [4:0] ALU_AND  = 5'b00010;
  localparam logic [4:0] ALU_OR   = 5'b00011;
  localparam logic [4:0] ALU_SLL  = 5'b00100;
  localparam logic [4:0] ALU_SRA  = 5'b00101;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_EXC
  } state_e;

  localparam logic [31:0] RS_ADD_OVF  = 32'd1;
  localparam logic [31:0] RS_ADDI_OVF = 32'd2;
  localparam logic [31:0] RS_SUB_OVF  = 32'd3;

  localparam logic [1:0] WSEL_ALU     = 2'd0;
  localparam logic [1:0] WSEL_DMEM    = 2'd1;
  localparam logic [1:0] WSEL_RSTATUS = 2'd2;

  // Exception code for an overflowing instruction. Only add, sub and
  // addi can reach the exception state, so anything that is not addi
  // and not sub is an add.
  function automatic logic [31:0] ovf_code(input logic is_addi,
                                           input logic [4:0] aluop);
    if (is_addi)
      return RS_ADDI_OVF;
    else if (aluop == ALU_SUB)
      return RS_SUB_OVF;
    else
      return RS_ADD_OVF;
  endfunction

endpackage

// File: rtl/insn_field_decode.sv
// Combinational instruction decoder.
// Slices the instruction register into its fields, sign-extends the
// 17-bit immediate and produces the class flags the sequencer uses.
// Ports:
//   ir          in   instruction register
//   rd/rs/rt    out  register fields
//   shamt       out  shift amount field
//   aluop       out  raw R-type function field
//   alu_sel     out  ALU op to drive (function field for R-type, add otherwise)
//   imm_ext     out  sign-extended immediate
//   is_rtype, is_load, is_store, is_mem, ovf_capable, illegal  out  class flags
module insn_field_decode
  import proc_ctrl_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [31:0]       ir,
  output logic [4:0]        rd,
  output logic [4:0]        rs,
  output logic [4:0]        rt,
  output logic [4:0]        shamt,
  output logic [4:0]        aluop,
  output logic [4:0]        alu_sel,
  output logic [DATA_W-1:0] imm_ext,
  output logic              is_rtype,
  output logic              is_load,
  output logic              is_store,
  output logic              is_mem,
  output logic              ovf_capable,
  output logic              illegal
);

  logic [4:0] opcode;
  logic       is_addi;
  logic       rtype_ok;

  always_comb begin
    opcode   = ir[31:27];
    rd       = ir[26:22];
    rs       = ir[21:17];
    rt       = ir[16:12];
    shamt    = ir[11:7];
    aluop    = ir[6:2];
    imm_ext  = {{(DATA_W-17){ir[16]}}, ir[16:0]};

    is_rtype = (opcode == OP_RTYPE);
    is_addi  = (opcode == OP_ADDI);
    is_load  = (opcode == OP_LW);
    is_store = (opcode == OP_SW);
    is_mem   = is_load | is_store;

    // Only add..sra are implemented; other function codes are treated
    // like an unsupported opcode.
    rtype_ok = (aluop <= ALU_SRA);
    illegal  = !((is_rtype && rtype_ok) || is_addi || is_mem);

    // Loads and stores use the ALU to form imm + $rs.
    alu_sel  = is_rtype ? aluop : ALU_ADD;

    ovf_capable = (is_rtype && (aluop == ALU_ADD || aluop == ALU_SUB)) || is_addi;
  end

endmodule

// File: rtl/proc_cycle_sequencer.sv
// Multi-cycle control sequencer for the five-field 32-bit ISA core.
// Fetches through an imem req/ack handshake, decodes, then steps the ALU,
// data memory and regfile write port one stage per clock. Arithmetic
// overflow on add/sub/addi writes an exception code into rstatus ($30).
// Ports:
//   clock, reset                 single clock, synchronous active-high reset
//   imem_req/imem_ack/instr      instruction fetch handshake
//   pc_inc                       one-cycle PC advance pulse at retirement
//   rs_addr/rt_addr              regfile read addresses
//   alu_op/shamt/alu_bsel/imm_ext/alu_load/alu_overflow  ALU control
//   dmem_req/dmem_we/dmem_ack    data memory handshake
//   rf_we/rf_waddr/rf_wsel/rstatus  regfile write port control
//   illegal                      sticky unsupported-opcode flag
//   insn_count                   retired-instruction counter
module proc_cycle_sequencer
  import proc_ctrl_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int RSTATUS_REG = 30,
  parameter int CNT_W       = 32
) (
  input  logic              clock,
  input  logic              reset,
  output logic              imem_req,
  input  logic              imem_ack,
  input  logic [31:0]       instr,
  output logic              pc_inc,
  output logic [4:0]        rs_addr,
  output logic [4:0]        rt_addr,
  output logic [4:0]        alu_op,
  output logic [4:0]        shamt,
  output logic              alu_bsel,
  output logic [DATA_W-1:0] imm_ext,
  output logic              alu_load,
  input  logic              alu_overflow,
  output logic              dmem_req,
  output logic              dmem_we,
  input  logic              dmem_ack,
  output logic              rf_we,
  output logic [4:0]        rf_waddr,
  output logic [1:0]        rf_wsel,
  output logic [DATA_W-1:0] rstatus,
  output logic              illegal,
  output logic [CNT_W-1:0]  insn_count
);

  state_e           state_q, state_d;
  logic [31:0]      ir_q, ir_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // High for the cycle after any reset edge so every output, including
  // imem_req, stays low until the cycle after reset is released.
  logic             rst_hold_q, rst_hold_d;
  logic             drive_ops;

  logic [4:0]        dec_rd, dec_rs, dec_rt, dec_shamt, dec_aluop, dec_alu_sel;
  logic [DATA_W-1:0] dec_imm_ext;
  logic              dec_is_rtype, dec_is_load, dec_is_store, dec_is_mem;
  logic              dec_ovf_capable, dec_illegal;

  insn_field_decode #(
    .DATA_W (DATA_W)
  ) u_decode (
    .ir          (ir_q),
    .rd          (dec_rd),
    .rs          (dec_rs),
    .rt          (dec_rt),
    .shamt       (dec_shamt),
    .aluop       (dec_aluop),
    .alu_sel     (dec_alu_sel),
    .imm_ext     (dec_imm_ext),
    .is_rtype    (dec_is_rtype),
    .is_load     (dec_is_load),
    .is_store    (dec_is_store),
    .is_mem      (dec_is_mem),
    .ovf_capable (dec_ovf_capable),
    .illegal     (dec_illegal)
  );

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_FETCH;
      rst_hold_q <= 1'b1;
      illegal_q  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      rst_hold_q <= rst_hold_d;
      illegal_q  <= illegal_d;
      cnt_q      <= cnt_d;
    end
  end

  // The instruction register is pure data and only loads on a fetch ack.
  always_ff @(posedge clock) begin
    ir_q <= ir_d;
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    ir_d       = ir_q;
    illegal_d  = illegal_q;
    cnt_d      = cnt_q;
    rst_hold_d = 1'b0;
    unique case (state_q)
      ST_FETCH: begin
        if (!rst_hold_q && imem_ack) begin
          ir_d    = instr;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (dec_illegal) begin
          illegal_d = 1'b1;
          state_d   = ST_FETCH;
        end else begin
          state_d   = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (dec_ovf_capable && alu_overflow)
          state_d = ST_EXC;
        else if (dec_is_mem)
          state_d = ST_MEM;
        else
          state_d = ST_WB;
      end
      ST_MEM: begin
        if (dmem_ack) begin
          if (dec_is_store) begin
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end
      end
      ST_WB, ST_EXC: begin
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = ST_FETCH;
      end
      default: state_d = ST_FETCH;
    endcase
  end

  // Output logic
  always_comb begin
    imem_req = 1'b0;
    pc_inc   = 1'b0;
    rs_addr  = '0;
    rt_addr  = '0;
    alu_op   = '0;
    shamt    = '0;
    alu_bsel = 1'b0;
    imm_ext  = '0;
    alu_load = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wsel  = WSEL_ALU;
    rstatus  = '0;

    // Operand/ALU controls stay valid from decode through memory so the
    // datapath can use the store data and address in MEM.
    drive_ops = (state_q == ST_DECODE) || (state_q == ST_EXEC) || (state_q == ST_MEM);
    if (drive_ops) begin
      rs_addr  = dec_rs;
      rt_addr  = dec_is_store ? dec_rd : dec_rt;
      alu_op   = dec_alu_sel;
      shamt    = dec_shamt;
      alu_bsel = !dec_is_rtype;
      imm_ext  = dec_imm_ext;
    end

    unique case (state_q)
      ST_FETCH:  imem_req = !rst_hold_q;
      ST_DECODE: pc_inc   = dec_illegal;
      ST_EXEC:   alu_load = 1'b1;
      ST_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = dec_is_store;
        pc_inc   = dmem_ack && dec_is_store;
      end
      ST_WB: begin
        rf_we    = (dec_rd != 5'd0);
        rf_waddr = dec_rd;
        rf_wsel  = dec_is_load ? WSEL_DMEM : WSEL_ALU;
        pc_inc   = 1'b1;
      end
      ST_EXC: begin
        rf_we    = 1'b1;
        rf_waddr = 5'(RSTATUS_REG);
        rf_wsel  = WSEL_RSTATUS;
        rstatus  = DATA_W'(ovf_code(!dec_is_rtype, dec_aluop));
        pc_inc   = 1'b1;
      end
      default: ;
    endcase
  end

  assign illegal    = illegal_q;
  assign insn_count = cnt_q;

endmodule

// File: tb/tb_proc_cycle_sequencer.sv
module tb_proc_cycle_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        imem_req, imem_ack;
  logic [31:0] instr;
  logic        pc_inc;
  logic [4:0]  rs_addr, rt_addr, alu_op, shamt;
  logic        alu_bsel;
  logic [31:0] imm_ext;
  logic        alu_load, alu_overflow;
  logic        dmem_req, dmem_we, dmem_ack;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [1:0]  rf_wsel;
  logic [31:0] rstatus;
  logic        illegal;
  logic [31:0] insn_count;

  proc_cycle_sequencer #(.DATA_W(32), .RSTATUS_REG(30), .CNT_W(32)) dut (
    .clock(clock), .reset(reset), .imem_req(imem_req), .imem_ack(imem_ack),
    .instr(instr), .pc_inc(pc_inc), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .alu_op(alu_op), .shamt(shamt), .alu_bsel(alu_bsel), .imm_ext(imm_ext),
    .alu_load(alu_load), .alu_overflow(alu_overflow), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_ack(dmem_ack), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wsel(rf_wsel), .rstatus(rstatus), .illegal(illegal), .insn_count(insn_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] w;
    bit          ill;
    int          lat;
    int          icyc;
    int          dcyc;
    bit          dwe;
    bit          rfwe;
    logic [4:0]  waddr;
    logic [1:0]  wsel;
    logic [31:0] rstat;
    logic [4:0]  rs, rt, aop, sh;
    bit          bsel;
    logic [31:0] imm;
    bit          chk_rt;
    bit          is_r;
    int          loads;
    int          cnt_before;
    bit          ill_before;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   mdl_cnt  = 0;
  bit   mdl_ill  = 0;
  bit   mon_en   = 0;
  bit   aborted  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Reference model: instruction-level outcome straight from the ISA rules.
  function automatic exp_t model(input logic [31:0] w, input bit ovf, input int iw, input int dw);
    exp_t e;
    logic [4:0] op, rd, fn;
    bit legal, hit;
    e = '{default: 0};
    e.w = w;
    op = w[31:27]; rd = w[26:22]; fn = w[6:2];
    legal = (op == 5'd0 && fn <= 5'd5) || op == 5'd5 || op == 5'd7 || op == 5'd8;
    e.icyc = iw + 1;
    if (!legal) begin
      e.ill = 1; e.lat = iw + 2;
      return e;
    end
    e.is_r   = (op == 5'd0);
    e.rs     = w[21:17];
    e.rt     = (op == 5'd7) ? rd : w[16:12];
    e.chk_rt = (op == 5'd0) || (op == 5'd7);
    e.aop    = e.is_r ? fn : 5'd0;
    e.sh     = w[11:7];
    e.bsel   = !e.is_r;
    e.imm    = {{15{w[16]}}, w[16:0]};
    e.loads  = 1;
    hit = ovf && ((e.is_r && (fn == 5'd0 || fn == 5'd1)) || op == 5'd5);
    if (hit) begin
      e.rfwe = 1; e.waddr = 5'd30; e.wsel = 2'd2;
      e.rstat = (op == 5'd5) ? 32'd2 : (fn == 5'd0 ? 32'd1 : 32'd3);
      e.lat = iw + 4;
    end else if (op == 5'd7) begin
      e.dcyc = dw + 1; e.dwe = 1; e.lat = iw + 4 + dw;
    end else if (op == 5'd8) begin
      e.dcyc = dw + 1; e.rfwe = (rd != 0); e.waddr = rd; e.wsel = 2'd1; e.lat = iw + 5 + dw;
    end else begin
      e.rfwe = (rd != 0); e.waddr = rd; e.wsel = 2'd0; e.lat = iw + 4;
    end
    return e;
  endfunction

  function automatic logic [31:0] rand_insn();
    logic [31:0] w;
    logic [4:0]  op;
    int k;
    w = $urandom;
    k = $urandom_range(0, 6);
    case (k)
      0: begin w[31:27] = 5'd0; w[6:2] = 5'($urandom_range(0, 5)); end
      1: w[31:27] = 5'd5;
      2: w[31:27] = 5'd7;
      3: w[31:27] = 5'd8;
      4: begin w[31:27] = 5'd0; w[6:2] = 5'($urandom_range(0, 1)); w[26:22] = 5'd0; end
      5: begin w[31:27] = 5'd0; w[6:2] = 5'($urandom_range(6, 31)); end
      default: begin
        do op = 5'($urandom); while (op == 5'd0 || op == 5'd5 || op == 5'd7 || op == 5'd8);
        w[31:27] = op;
      end
    endcase
    return w;
  endfunction

  task automatic do_fetch(input logic [31:0] w, input int iw, output bit ok);
    int n = 0;
    bit hit;
    ok = 0;
    for (int b = 0; b < 64; b++) begin
      @(negedge clock);
      hit = 0;
      if (imem_req) begin
        if (n == iw) begin imem_ack = 1; instr = w; hit = 1; end
        else if ($urandom_range(0, 1) == 1) dmem_ack = 1;
        n++;
      end
      @(posedge clock); #1;
      imem_ack = 0; dmem_ack = 0; instr = $urandom;
      if (hit) begin ok = 1; return; end
    end
  endtask

  task automatic run_body(input int dw, output bit ok);
    int n = 0;
    bit done;
    ok = 0;
    for (int b = 0; b < 64; b++) begin
      @(negedge clock);
      if (dmem_req) begin
        if (n == dw) dmem_ack = 1;
        n++;
      end else if ($urandom_range(0, 3) == 0) dmem_ack = 1;
      if (!imem_req && $urandom_range(0, 3) == 0) imem_ack = 1;
      #1;
      done = pc_inc;
      @(posedge clock); #1;
      dmem_ack = 0; imem_ack = 0;
      if (done) begin ok = 1; return; end
    end
  endtask

  task automatic issue(input logic [31:0] w, input bit ovf, input int iw, input int dw);
    exp_t e;
    bit ok;
    e = model(w, ovf, iw, dw);
    e.cnt_before = mdl_cnt;
    e.ill_before = mdl_ill;
    if (e.ill) mdl_ill = 1; else mdl_cnt++;
    exp_q.push_back(e);
    alu_overflow = ovf;
    do_fetch(w, iw, ok);
    if (ok) run_body(dw, ok);
    if (!ok) begin chk("handshake_timeout", 64'(0), 64'(1)); aborted = 1; end
  endtask

  // Monitor state, accumulated per instruction and compared at pc_inc.
  exp_t        m_e;
  bit          m_started, m_prev_acc, m_dwe, m_both, m_dec;
  int          m_cyc, m_icyc, m_dcyc, m_rfwe, m_loads;
  logic [4:0]  m_waddr, m_rs, m_rt, m_aop, m_sh;
  logic [1:0]  m_wsel;
  logic [31:0] m_rstat, m_imm;
  bit          m_bsel;

  task automatic mon_clear();
    m_started = 0; m_prev_acc = 0; m_dwe = 0; m_both = 0; m_dec = 0;
    m_cyc = 0; m_icyc = 0; m_dcyc = 0; m_rfwe = 0; m_loads = 0;
    m_waddr = 0; m_wsel = 0; m_rstat = 0;
    m_rs = 0; m_rt = 0; m_aop = 0; m_sh = 0; m_imm = 0; m_bsel = 0;
  endtask

  initial begin : monitor
    mon_clear();
    forever begin
      @(negedge clock); #1;
      if (!mon_en) mon_clear();
      else begin
        if (imem_req) m_started = 1;
        if (m_started) m_cyc++;
        if (imem_req) m_icyc++;
        if (dmem_req) begin m_dcyc++; if (dmem_we) m_dwe = 1; end
        if (imem_req && dmem_req) m_both = 1;
        if (alu_load) m_loads++;
        if (m_prev_acc) begin
          m_dec = 1; m_rs = rs_addr; m_rt = rt_addr; m_aop = alu_op;
          m_sh = shamt; m_imm = imm_ext; m_bsel = alu_bsel;
        end
        if (rf_we) begin m_rfwe++; m_waddr = rf_waddr; m_wsel = rf_wsel; m_rstat = rstatus; end
        m_prev_acc = imem_req && imem_ack;
        if (pc_inc) begin
          if (exp_q.size() == 0) chk("unexpected_pc_inc", 64'(1), 64'(0));
          else begin
            m_e = exp_q.pop_front();
            chk($sformatf("latency[%h]", m_e.w), 64'(m_cyc), 64'(m_e.lat));
            chk($sformatf("imem_req_cycles[%h]", m_e.w), 64'(m_icyc), 64'(m_e.icyc));
            chk($sformatf("dmem_req_cycles[%h]", m_e.w), 64'(m_dcyc), 64'(m_e.dcyc));
            chk($sformatf("dmem_we[%h]", m_e.w), 64'(m_dwe), 64'(m_e.dwe));
            chk($sformatf("rf_we_count[%h]", m_e.w), 64'(m_rfwe), 64'(m_e.rfwe));
            chk($sformatf("alu_load_count[%h]", m_e.w), 64'(m_loads), 64'(m_e.loads));
            chk($sformatf("req_overlap[%h]", m_e.w), 64'(m_both), 64'(0));
            chk($sformatf("count_before[%h]", m_e.w), 64'(insn_count), 64'(m_e.cnt_before));
            chk($sformatf("illegal_before[%h]", m_e.w), 64'(illegal), 64'(m_e.ill_before));
            if (m_e.rfwe) begin
              chk($sformatf("rf_waddr[%h]", m_e.w), 64'(m_waddr), 64'(m_e.waddr));
              chk($sformatf("rf_wsel[%h]", m_e.w), 64'(m_wsel), 64'(m_e.wsel));
              chk($sformatf("rstatus[%h]", m_e.w), 64'(m_rstat), 64'(m_e.rstat));
            end
            if (!m_e.ill) begin
              chk($sformatf("decode_seen[%h]", m_e.w), 64'(m_dec), 64'(1));
              chk($sformatf("rs_addr[%h]", m_e.w), 64'(m_rs), 64'(m_e.rs));
              chk($sformatf("alu_op[%h]", m_e.w), 64'(m_aop), 64'(m_e.aop));
              chk($sformatf("alu_bsel[%h]", m_e.w), 64'(m_bsel), 64'(m_e.bsel));
              if (m_e.chk_rt) chk($sformatf("rt_addr[%h]", m_e.w), 64'(m_rt), 64'(m_e.rt));
              if (m_e.is_r) chk($sformatf("shamt[%h]", m_e.w), 64'(m_sh), 64'(m_e.sh));
              else chk($sformatf("imm_ext[%h]", m_e.w), 64'(m_imm), 64'(m_e.imm));
            end
          end
          mon_clear();
        end
      end
    end
  end

  task automatic chk_quiet(input string tag);
    chk({tag, "_ctrl"}, 64'({imem_req, pc_inc, rs_addr, rt_addr, alu_op, shamt, alu_bsel,
                             alu_load, dmem_req, dmem_we, rf_we, rf_waddr, rf_wsel}), 64'(0));
    chk({tag, "_imm_ext"}, 64'(imm_ext), 64'(0));
    chk({tag, "_rstatus"}, 64'(rstatus), 64'(0));
    chk({tag, "_insn_count"}, 64'(insn_count), 64'(0));
    chk({tag, "_illegal"}, 64'(illegal), 64'(0));
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    bit ok;
    reset = 1; imem_ack = 0; dmem_ack = 0; instr = 0; alu_overflow = 0;
    repeat (3) @(posedge clock);
    @(negedge clock); #1;
    chk_quiet("reset");
    reset = 0;
    mon_en = 1;

    // Directed cases
    issue(32'h28400005, 0, 0, 0);                                   // addi $1,$0,5
    issue((32'd21 << 22) | (32'd20 << 17) | (32'd20 << 12), 1, 0, 0); // add $21,$20,$20 ovf
    issue((32'd7 << 27) | (32'd10 << 22) | 32'd1, 0, 0, 3);          // sw $10,1($0)
    issue((32'd8 << 27) | (32'd12 << 22) | 32'd1, 0, 2, 0);          // lw $12,1($0)
    issue((32'd5 << 27) | (32'd3 << 22) | 32'h10000, 0, 0, 0);       // addi negative imm
    issue((32'd5 << 27) | (32'd4 << 22) | 32'h1, 1, 1, 0);           // addi overflow
    issue((32'd0 << 27) | (32'd5 << 22) | (32'd1 << 2), 1, 0, 0);    // sub overflow
    issue((32'd0 << 27) | (32'd6 << 22) | (32'd2 << 2), 1, 0, 0);    // and, overflow ignored
    issue(32'hF8000000, 0, 0, 0);                                   // illegal opcode 11111
    issue((32'd0 << 27) | (32'd0 << 22) | (32'd3 << 2), 0, 0, 0);    // or to $0

    for (int i = 0; i < 60 && !aborted; i++)
      issue(rand_insn(), 1'($urandom_range(0, 1)), $urandom_range(0, 2), $urandom_range(0, 3));

    @(negedge clock); #1;
    chk("queue_drained", 64'(exp_q.size()), 64'(0));
    chk("final_insn_count", 64'(insn_count), 64'(mdl_cnt));
    chk("final_illegal", 64'(illegal), 64'(mdl_ill));

    // Reset while a load sits in MEM waiting for dmem_ack
    if (!aborted) begin
      mon_en = 0;
      alu_overflow = 0;
      do_fetch((32'd8 << 27) | (32'd7 << 22) | 32'd4, 0, ok);
      for (int b = 0; b < 20 && ok; b++) begin
        @(negedge clock);
        if (dmem_req) break;
      end
      chk("reach_mem", 64'(dmem_req), 64'(1));
      reset = 1;
      @(negedge clock); #1;
      chk_quiet("mid_reset");
      reset = 0;
      exp_q.delete();
      mdl_cnt = 0;
      mdl_ill = 0;
      mon_en = 1;
      issue((32'd5 << 27) | (32'd9 << 22) | 32'd7, 0, 2, 0);
      @(negedge clock); #1;
      chk("post_reset_queue", 64'(exp_q.size()), 64'(0));
      chk("post_reset_count", 64'(insn_count), 64'(1));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
